// File: rtl/xcvr_reset_seq_pkg.sv
// Shared types for the transceiver reset sequencer: state encoding, the
// registered output bundle and the mapping from state to output levels.
package xcvr_reset_pkg;

   localparam int RelockWidth = 8;

   typedef enum logic [2:0] {
      IDLE,
      PLL_RST,
      WAIT_LOCK,
      SETTLE,
      ANA_REL,
      DIG_REL,
      RUN,
      FAIL
   } xcvr_reset_state_t;

   typedef struct packed {
      logic pll_powerdown;
      logic analogreset;
      logic digitalreset;
      logic reset_out;
      logic error;
   } xcvr_reset_outs_t;

   // Output levels held while resident in a given state. Registering this at
   // every state change keeps the outputs glitch-free and in step with state.
   function automatic xcvr_reset_outs_t outs_for(input xcvr_reset_state_t s);
      xcvr_reset_outs_t o;
      o.pll_powerdown = (s == IDLE) || (s == PLL_RST) || (s == FAIL);
      o.analogreset   = !((s == ANA_REL) || (s == DIG_REL) || (s == RUN));
      o.digitalreset  = !((s == DIG_REL) || (s == RUN));
      o.reset_out     = (s != RUN);
      o.error         = (s == FAIL);
      return o;
   endfunction

endpackage

// File: rtl/xcvr_reset_seq_if.sv
// Control/status bundle between the reset sequencer and its surroundings
// (Si570 controller, transceiver PHY, downstream MAC).
interface xcvr_reset_seq_if;
   import xcvr_reset_pkg::*;

   logic                   refclk_reset;
   logic                   pll_locked;
   logic                   rx_cal_busy;
   logic                   pll_powerdown;
   logic                   xcvr_analogreset;
   logic                   xcvr_digitalreset;
   logic                   reset_out;
   logic                   error;
   logic [RelockWidth-1:0] relock_count;

   modport master (
      output refclk_reset, pll_locked, rx_cal_busy,
      input  pll_powerdown, xcvr_analogreset, xcvr_digitalreset,
             reset_out, error, relock_count
   );

   modport slave (
      input  refclk_reset, pll_locked, rx_cal_busy,
      output pll_powerdown, xcvr_analogreset, xcvr_digitalreset,
             reset_out, error, relock_count
   );

endinterface

// File: rtl/xcvr_reset_seq_bit_sync.sv
// Two-flop synchroniser for a single asynchronous level. The reset value is
// chosen per instance so that an unknown input reads as the safe level.
module bit_sync #(
   parameter logic ResetValue = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Shift the asynchronous input through two stages.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= ResetValue;
         q    <= ResetValue;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/xcvr_reset_seq.sv
// Transceiver reset sequencer: after the reference clock is valid, pulses the
// PLL reset, waits for lock, requires lock to be stable, then releases the
// analog and digital PHY resets in order and finally the downstream reset.
// Loss of lock in RUN re-sequences; repeated lock timeouts end in FAIL.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | refclk not valid, everything held in reset
// PLL_RST   | pll_powerdown asserted for PllResetCycles
// WAIT_LOCK | PLL released, waiting for lock (bounded by LockTimeoutCycles)
// SETTLE    | lock must stay high for StableCycles in a row
// ANA_REL   | analog reset released, waiting for cal idle + DigitalDelayCycles
// DIG_REL   | digital reset released, one cycle before RUN
// RUN       | downstream reset released, lock supervised
// FAIL      | lock never achieved after MaxRetries attempts, error high
module xcvr_reset_seq
   import xcvr_reset_pkg::*;
#(
   parameter int PllResetCycles     = 1000,
   parameter int LockTimeoutCycles  = 5000000,
   parameter int StableCycles       = 50000,
   parameter int DigitalDelayCycles = 2000,
   parameter int MaxRetries         = 7
) (
   input logic             clk,
   input logic             reset_n,
   xcvr_reset_seq_if.slave bus
);

   localparam int MaxAB      = (PllResetCycles > LockTimeoutCycles) ? PllResetCycles : LockTimeoutCycles;
   localparam int MaxCD      = (StableCycles > DigitalDelayCycles) ? StableCycles : DigitalDelayCycles;
   localparam int MaxCycles  = (MaxAB > MaxCD) ? MaxAB : MaxCD;
   localparam int TimerWidth = $clog2(MaxCycles + 1);
   localparam int RetryWidth = (MaxRetries < 1) ? 1 : $clog2(MaxRetries + 1);

   // Timer reload values: a phase of N cycles counts N-1 down to 0.
   localparam logic [TimerWidth-1:0] PllLoad    = TimerWidth'(PllResetCycles - 1);
   localparam logic [TimerWidth-1:0] LockLoad   = TimerWidth'(LockTimeoutCycles - 1);
   localparam logic [TimerWidth-1:0] StableLoad = TimerWidth'(StableCycles - 1);
   localparam logic [TimerWidth-1:0] DigLoad    = TimerWidth'(DigitalDelayCycles - 1);
   localparam logic [TimerWidth-1:0] TimerOne   = TimerWidth'(1);
   localparam logic [RetryWidth-1:0] RetryLast  = RetryWidth'(MaxRetries - 1);
   localparam logic [RetryWidth-1:0] RetryOne   = RetryWidth'(1);
   localparam logic [RelockWidth-1:0] RelockOne = RelockWidth'(1);

   xcvr_reset_state_t      state;
   xcvr_reset_outs_t       outs;
   logic [TimerWidth-1:0]  timer;
   logic [RetryWidth-1:0]  retry;
   logic [RelockWidth-1:0] relock;
   logic                   lock_s;
   logic                   busy_s;

   // Lock resets to "not locked"; calibration resets to "busy" so neither can
   // release anything before real synchronised values arrive.
   bit_sync #(.ResetValue(1'b0)) u_lock_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (bus.pll_locked),
      .q       (lock_s)
   );

   bit_sync #(.ResetValue(1'b1)) u_busy_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (bus.rx_cal_busy),
      .q       (busy_s)
   );

   // Sequencer: refclk_reset pre-empts every state, outputs follow next state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         outs   <= outs_for(IDLE);
         timer  <= '0;
         retry  <= '0;
         relock <= '0;
      end else if (bus.refclk_reset) begin
         state <= IDLE;
         outs  <= outs_for(IDLE);
         timer <= '0;
         retry <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               state <= PLL_RST;
               outs  <= outs_for(PLL_RST);
               timer <= PllLoad;
            end
            PLL_RST: begin
               if (timer == '0) begin
                  state <= WAIT_LOCK;
                  outs  <= outs_for(WAIT_LOCK);
                  timer <= LockLoad;
               end else begin
                  timer <= timer - TimerOne;
               end
            end
            WAIT_LOCK: begin
               if (lock_s) begin
                  state <= SETTLE;
                  outs  <= outs_for(SETTLE);
                  timer <= StableLoad;
               end else if (timer == '0) begin
                  retry <= retry + RetryOne;
                  if (retry == RetryLast) begin
                     state <= FAIL;
                     outs  <= outs_for(FAIL);
                  end else begin
                     state <= PLL_RST;
                     outs  <= outs_for(PLL_RST);
                     timer <= PllLoad;
                  end
               end else begin
                  timer <= timer - TimerOne;
               end
            end
            SETTLE: begin
               if (!lock_s) begin
                  timer <= StableLoad;
               end else if (timer == '0) begin
                  state <= ANA_REL;
                  outs  <= outs_for(ANA_REL);
                  timer <= DigLoad;
                  retry <= '0;
               end else begin
                  timer <= timer - TimerOne;
               end
            end
            ANA_REL: begin
               // The digital delay only starts counting once calibration is idle.
               if (busy_s) begin
                  timer <= DigLoad;
               end else if (timer == '0) begin
                  state <= DIG_REL;
                  outs  <= outs_for(DIG_REL);
               end else begin
                  timer <= timer - TimerOne;
               end
            end
            DIG_REL: begin
               state <= RUN;
               outs  <= outs_for(RUN);
            end
            RUN: begin
               if (!lock_s) begin
                  state <= PLL_RST;
                  outs  <= outs_for(PLL_RST);
                  timer <= PllLoad;
                  if (relock != '1) begin
                     relock <= relock + RelockOne;
                  end
               end
            end
            FAIL: begin
               state <= FAIL;
            end
            default: begin
               state <= IDLE;
               outs  <= outs_for(IDLE);
            end
         endcase
      end
   end

   assign bus.pll_powerdown     = outs.pll_powerdown;
   assign bus.xcvr_analogreset  = outs.analogreset;
   assign bus.xcvr_digitalreset = outs.digitalreset;
   assign bus.reset_out         = outs.reset_out;
   assign bus.error             = outs.error;
   assign bus.relock_count      = relock;

endmodule

// File: doc/xcvr_reset_seq.md
Name: xcvr_reset_seq

Overview:
- Consumes the active-high "reference clock not ready" reset produced by the Si570 configuration controller.
- Sequences transceiver PLL and PHY resets once the reference clock is stable: waits for PLL lock, applies a settle period, then releases analog resets and digital resets in order.
- Supervises lock in the run state and re-sequences on loss of lock, with retry/timeout accounting and a sticky error on persistent failure.
- Sits between the Si570 controller and the transceiver PHY/MAC in the FC port datapath.

Parameters:
- PllResetCycles, 1000: cycles pll_powerdown is held asserted per attempt.
- LockTimeoutCycles, 5000000: max cycles to wait for PLL lock before a retry.
- StableCycles, 50000: cycles lock must be continuously high before analog release.
- DigitalDelayCycles, 2000: cycles between analog release and digital release.
- MaxRetries, 7: consecutive failed lock attempts before entering FAIL.

Ports:
- clk  in  1  system clock (free-running, independent of Si570 output)
- reset_n  in  1  asynchronous active-low reset
- refclk_reset  in  1  active-high; Si570 output not yet valid
- pll_locked  in  1  asynchronous PLL lock indicator
- rx_cal_busy  in  1  asynchronous PHY calibration busy
- pll_powerdown  out  1  active-high PLL reset
- xcvr_analogreset  out  1  active-high TX/RX analog reset
- xcvr_digitalreset  out  1  active-high TX/RX digital reset
- reset_out  out  1  active-high downstream reset; low only in RUN
- error  out  1  sticky; high in FAIL
- relock_count  out  8  saturating count of lock losses seen in RUN

Behaviour:
- Async reset: state=IDLE; pll_powerdown, xcvr_analogreset, xcvr_digitalreset and reset_out=1; error=0; relock_count=0; retry=0; timers=0.
- pll_locked and rx_cal_busy pass through a 2-flop synchroniser (2-cycle latency). All decisions use the synchronised values.
- Single down-counter timer, loaded on each state entry. Width is $clog2(max parameter + 1).
- States:
  - IDLE: all resets asserted. Leave to PLL_RST when refclk_reset == 0.
  - PLL_RST: pll_powerdown=1 for PllResetCycles, then WAIT_LOCK.
  - WAIT_LOCK: pll_powerdown=0.
    - Lock seen → SETTLE.
    - Timer expires → retry += 1. If retry == MaxRetries → FAIL, else → PLL_RST.
  - SETTLE: needs StableCycles with lock continuously high. Any lock drop reloads the timer and stays in SETTLE. On expiry: retry=0, go to ANA_REL.
  - ANA_REL: xcvr_analogreset=0. Wait until rx_cal_busy == 0, then DigitalDelayCycles, then DIG_REL.
  - DIG_REL: xcvr_digitalreset=0 for one cycle, then RUN.
  - RUN: reset_out=0.
    - Lock loss → relock_count += 1 (saturates at 255), all three PHY resets and reset_out reassert in the same cycle, go to PLL_RST.
  - FAIL: all resets asserted; error=1. Exit only via reset_n or a rising edge of refclk_reset.
- refclk_reset == 1 in any state overrides everything: next state IDLE, all resets asserted next cycle, retry cleared. relock_count and error are preserved, except error clears when leaving FAIL.
- If refclk_reset and loss of lock occur in the same cycle, refclk_reset wins and relock_count is not incremented.
- All outputs are registered. Minimum latency from refclk_reset deassert to reset_out low is 1 + PllResetCycles + 2 (sync) + StableCycles + DigitalDelayCycles + 2 cycles, ±1.
- Reset ordering invariant, all states: digital released ⇒ analog released ⇒ pll_powerdown low. The bench asserts this every cycle.

Decomposition:
- Shared package xcvr_reset_pkg holds:
  - state enum xcvr_reset_state_t (IDLE, PLL_RST, WAIT_LOCK, SETTLE, ANA_REL, DIG_REL, RUN, FAIL);
  - the relock_count width constant.
- One sub-module, bit_sync: a 2-flop synchroniser with async active-low reset and a reset-value parameter, instantiated twice.

Test Plan:
- Small params (PllResetCycles=4, LockTimeoutCycles=20, StableCycles=8, DigitalDelayCycles=3, MaxRetries=2). refclk_reset falls; pll_locked rises 5 cycles after pll_powerdown falls → reset_out falls after the computed latency; ordering invariant holds throughout.
- pll_locked never rises → two PLL_RST pulses of 4 cycles each, each followed by a 20-cycle wait. FAIL is then entered with error=1 and all resets high. A refclk_reset pulse clears error and restarts the sequence.
- pll_locked glitches low for 1 cycle at cycle 5 of SETTLE → SETTLE restarts; analog release comes 8 cycles after the glitch ends, not earlier.
- In RUN, drop pll_locked 3 times → relock_count=3, each followed by full re-sequence. Force 300 losses → relock_count saturates at 255.
- rx_cal_busy held high 50 cycles in ANA_REL → xcvr_digitalreset falls exactly 3 cycles after busy clears plus sync delay.
- reset_n asserted mid-SETTLE and refclk_reset asserted mid-RUN → all outputs take reset values; the second case goes to IDLE next cycle with relock_count preserved.
